// File: rtl/riscv_mc_ctrl_hs_if.sv
// Control/status bundle between the multi-cycle controller and its datapath.
// master = controller side, slave = datapath/memory side.
interface riscv_mc_ctrl_hs_if #(
    parameter int unsigned CNT_W = 32
);
    logic [6:0]       op;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic             Zero;
    logic             cout;
    logic             overflow;
    logic             sign;
    logic             mem_ready;
    logic [2:0]       ImmSrc;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ResultSrc;
    logic             AdrSrc;
    logic [3:0]       ALUControl;
    logic             IRWrite;
    logic             PCWrite;
    logic             RegWrite;
    logic             MemWrite;
    logic             mem_req;
    logic             illegal;
    logic             bus_err;
    logic [CNT_W-1:0] instret;

    modport master (
        input  op, funct3, funct7b5,
        input  Zero, cout, overflow, sign,
        input  mem_ready,
        output ImmSrc, ALUSrcA, ALUSrcB, ResultSrc,
        output AdrSrc, ALUControl,
        output IRWrite, PCWrite, RegWrite, MemWrite,
        output mem_req, illegal, bus_err, instret
    );

    modport slave (
        output op, funct3, funct7b5,
        output Zero, cout, overflow, sign,
        output mem_ready,
        input  ImmSrc, ALUSrcA, ALUSrcB, ResultSrc,
        input  AdrSrc, ALUControl,
        input  IRWrite, PCWrite, RegWrite, MemWrite,
        input  mem_req, illegal, bus_err, instret
    );
endinterface

// File: rtl/riscv_mc_ctrl_hs.sv
// Multi-cycle RV32I control FSM with memory ready/valid stalls,
// illegal-op and bus-timeout traps, and a retired-instruction counter.
module riscv_mc_ctrl_hs #(
    parameter int unsigned TIMEOUT = 0,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    riscv_mc_ctrl_hs_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR1,
        S_JALR2,
        S_TRAP
    } state_e;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_FENCE = 7'b0001111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] A_PC    = 2'b00;
    localparam logic [1:0] A_OLDPC = 2'b01;
    localparam logic [1:0] A_RS1   = 2'b10;
    localparam logic [1:0] A_ZERO  = 2'b11;

    localparam logic [1:0] B_RS2  = 2'b00;
    localparam logic [1:0] B_IMM  = 2'b01;
    localparam logic [1:0] B_FOUR = 2'b10;

    localparam logic [1:0] R_ALUOUT = 2'b00;
    localparam logic [1:0] R_DATA   = 2'b01;
    localparam logic [1:0] R_ALURES = 2'b10;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    state_e           state_q, state_d;
    logic [31:0]      wait_q, wait_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;

    logic             retire;
    logic             mem_st;
    logic             tmo;
    logic             lt, ltu;
    logic             taken, br_bad;
    logic [3:0]       alu_fn;

    logic [2:0]       imm_c;
    logic [1:0]       a_c, b_c, res_c;
    logic             adr_c;
    logic [3:0]       alu_c;
    logic             irw_c, pcw_c, regw_c, memw_c, req_c;

    assign lt  = bus.sign ^ bus.overflow;
    assign ltu = ~bus.cout;

    assign mem_st = (state_q == S_FETCH)
                 || (state_q == S_MEMREAD)
                 || (state_q == S_MEMWRITE);

    // Timeout fires on the wait cycle that would bring the count to TIMEOUT.
    assign tmo = (TIMEOUT != 0) && !bus.mem_ready
              && (wait_q == 32'(TIMEOUT - 1));

    // ALU function for R/I arithmetic; sub only exists in R-type.
    always_comb begin
        alu_fn = ALU_ADD;
        case (bus.funct3)
            3'b000: alu_fn = (state_q == S_EXEC_R && bus.funct7b5)
                           ? ALU_SUB : ALU_ADD;
            3'b001: alu_fn = ALU_SLL;
            3'b010: alu_fn = ALU_SLT;
            3'b011: alu_fn = ALU_SLTU;
            3'b100: alu_fn = ALU_XOR;
            3'b101: alu_fn = bus.funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110: alu_fn = ALU_OR;
            default: alu_fn = ALU_AND;
        endcase
    end

    // Branch condition from the ALU flags of rs1 - rs2.
    always_comb begin
        taken  = 1'b0;
        br_bad = 1'b0;
        case (bus.funct3)
            3'b000: taken = bus.Zero;
            3'b001: taken = ~bus.Zero;
            3'b100: taken = lt;
            3'b101: taken = ~lt;
            3'b110: taken = ltu;
            3'b111: taken = ~ltu;
            default: br_bad = 1'b1;
        endcase
    end

    // Next-state, Mealy control outputs and trap/retire bookkeeping.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        retire    = 1'b0;
        imm_c     = IMM_I;
        a_c       = A_PC;
        b_c       = B_RS2;
        res_c     = R_ALUOUT;
        adr_c     = 1'b0;
        alu_c     = ALU_ADD;
        irw_c     = 1'b0;
        pcw_c     = 1'b0;
        regw_c    = 1'b0;
        memw_c    = 1'b0;
        req_c     = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                req_c = 1'b1;
                a_c   = A_PC;
                b_c   = B_FOUR;
                res_c = R_ALURES;
                if (bus.mem_ready) begin
                    irw_c   = 1'b1;
                    pcw_c   = 1'b1;
                    state_d = S_DECODE;
                end else if (tmo) begin
                    bus_err_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_DECODE: begin
                a_c   = A_OLDPC;
                b_c   = B_IMM;
                imm_c = (bus.op == OP_JAL) ? IMM_J : IMM_B;
                case (bus.op)
                    OP_LOAD, OP_STORE:        state_d = S_MEMADR;
                    OP_R:                     state_d = S_EXEC_R;
                    OP_I, OP_LUI, OP_AUIPC:   state_d = S_EXEC_I;
                    OP_BR:                    state_d = S_BRANCH;
                    OP_JAL:                   state_d = S_JAL;
                    OP_JALR:                  state_d = S_JALR1;
                    OP_FENCE: begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_TRAP;
                    end
                endcase
            end
            S_MEMADR: begin
                a_c     = A_RS1;
                b_c     = B_IMM;
                imm_c   = bus.op[5] ? IMM_S : IMM_I;
                state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_c = 1'b1;
                req_c = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end else if (tmo) begin
                    bus_err_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_MEMWB: begin
                res_c   = R_DATA;
                regw_c  = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_c  = 1'b1;
                req_c  = 1'b1;
                memw_c = 1'b1;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (tmo) begin
                    bus_err_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_EXEC_R: begin
                a_c     = A_RS1;
                b_c     = B_RS2;
                alu_c   = alu_fn;
                state_d = S_ALUWB;
            end
            S_EXEC_I: begin
                b_c = B_IMM;
                if (bus.op == OP_LUI) begin
                    a_c   = A_ZERO;
                    imm_c = IMM_U;
                end else if (bus.op == OP_AUIPC) begin
                    a_c   = A_OLDPC;
                    imm_c = IMM_U;
                end else begin
                    a_c   = A_RS1;
                    imm_c = IMM_I;
                    alu_c = alu_fn;
                end
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                res_c   = R_ALUOUT;
                regw_c  = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                a_c   = A_RS1;
                b_c   = B_RS2;
                alu_c = ALU_SUB;
                imm_c = IMM_B;
                if (br_bad) begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    pcw_c   = taken;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_JAL, S_JALR2: begin
                pcw_c   = 1'b1;
                a_c     = A_OLDPC;
                b_c     = B_FOUR;
                state_d = S_ALUWB;
            end
            S_JALR1: begin
                a_c     = A_RS1;
                b_c     = B_IMM;
                imm_c   = IMM_I;
                state_d = S_JALR2;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (mem_st && !bus.mem_ready) begin
            wait_d = wait_q + 32'd1;
        end

        instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
    end

    // State, wait counter, retire counter and sticky trap flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Outputs are forced low while reset is held so an aborted access
    // cannot leave a write enable or request hanging.
    assign bus.ImmSrc     = reset ? imm_c  : '0;
    assign bus.ALUSrcA    = reset ? a_c    : '0;
    assign bus.ALUSrcB    = reset ? b_c    : '0;
    assign bus.ResultSrc  = reset ? res_c  : '0;
    assign bus.AdrSrc     = reset & adr_c;
    assign bus.ALUControl = reset ? alu_c  : '0;
    assign bus.IRWrite    = reset & irw_c;
    assign bus.PCWrite    = reset & pcw_c;
    assign bus.RegWrite   = reset & regw_c;
    assign bus.MemWrite   = reset & memw_c;
    assign bus.mem_req    = reset & req_c;
    assign bus.illegal    = illegal_q;
    assign bus.bus_err    = bus_err_q;
    assign bus.instret    = instret_q;
endmodule
